// File: rtl/uart_tx_sched.sv
// Round-robin, packet-granular scheduler feeding the UART wrapper's TX write port.
// Paces writes to one byte per frame time because the wrapper exposes no TX full flag.
module uart_tx_sched #(
    parameter int unsigned BYTE_CLKS = 26080,
    parameter int unsigned CNT_W     = 15,
    parameter int unsigned TMO_CLKS  = 65535,
    parameter int unsigned TMO_W     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       wr_uart,
    output logic [7:0] data_out,
    output logic [1:0] grant,
    output logic       busy,
    output logic       tmo_pulse
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    localparam logic [CNT_W-1:0] PaceLoad = CNT_W'(BYTE_CLKS - 1);
    localparam logic [TMO_W-1:0] TmoLast  = TMO_W'(TMO_CLKS - 1);

    state_e           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] pace_cnt_q, pace_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             wr_uart_q, wr_uart_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             tmo_pulse_q, tmo_pulse_d;

    logic       pace_idle;
    logic       sel_valid;
    logic [7:0] sel_data;
    logic       sel_last;
    logic       xfer;
    logic       win1;

    assign pace_idle  = (pace_cnt_q == '0);
    assign req0_ready = (state_q == StSend) & grant_q[0] & pace_idle;
    assign req1_ready = (state_q == StSend) & grant_q[1] & pace_idle;

    assign sel_valid = grant_q[1] ? req1_valid : req0_valid;
    assign sel_data  = grant_q[1] ? req1_data  : req0_data;
    assign sel_last  = grant_q[1] ? req1_last  : req0_last;
    assign xfer      = (req0_ready & req0_valid) | (req1_ready & req1_valid);

    // On a tie the requester that did not win last time goes first.
    assign win1 = req1_valid & (~req0_valid | ~last_grant_q);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pace_cnt_d   = pace_idle ? pace_cnt_q : pace_cnt_q - CNT_W'(1);
        tmo_cnt_d    = tmo_cnt_q;
        wr_uart_d    = 1'b0;
        data_out_d   = data_out_q;
        tmo_pulse_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req0_valid | req1_valid) begin
                    state_d      = StSend;
                    grant_d      = win1 ? 2'b10 : 2'b01;
                    last_grant_d = win1;
                    tmo_cnt_d    = '0;
                end
            end
            StSend: begin
                if (xfer) begin
                    wr_uart_d  = 1'b1;
                    data_out_d = sel_data;
                    pace_cnt_d = PaceLoad;
                    tmo_cnt_d  = '0;
                    if (sel_last) begin
                        state_d = StIdle;
                        grant_d = 2'b00;
                    end
                end else if (sel_valid) begin
                    // Stalled by pacing, not by the requester: no timeout progress.
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == TmoLast) begin
                    tmo_pulse_d = 1'b1;
                    tmo_cnt_d   = '0;
                    state_d     = StIdle;
                    grant_d     = 2'b00;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            pace_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            wr_uart_q    <= 1'b0;
            data_out_q   <= 8'h00;
            tmo_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pace_cnt_q   <= pace_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            wr_uart_q    <= wr_uart_d;
            data_out_q   <= data_out_d;
            tmo_pulse_q  <= tmo_pulse_d;
        end
    end

    assign wr_uart   = wr_uart_q;
    assign data_out  = data_out_q;
    assign grant     = grant_q;
    assign tmo_pulse = tmo_pulse_q;
    assign busy      = (state_q == StSend) | ~pace_idle;

endmodule
